// File: rtl/mem_arbiter.sv
// Two-port SRAM arbiter: one fixed 4-cycle access (IDLE/ACC1/ACC2/DONE) per grant, Ack in DONE.
// Optional MEM_ARBITER_ROUND_ROBIN_EN selects round-robin tie-break instead of fixed port-0 priority.
module mem_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              We0,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Wdata0,
    input  logic [DATA_W-1:0] Wdata1,
    output logic              Ack0,
    output logic              Ack1,
    output logic [DATA_W-1:0] Rdata0,
    output logic [DATA_W-1:0] Rdata1,
    output logic [ADDR_W-1:0] Mem_ADDR,
    output logic [DATA_W-1:0] Mem_Dout,
    output logic              Mem_Dout_en,
    input  logic [DATA_W-1:0] Mem_Din,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              Busy,
    output logic              Grant
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;
    logic                win;
    logic                active;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_q, last_d;

    // On a tie the port not served last wins; last resets to 1 so port 0 takes the first tie.
    assign win = (Req0 && Req1) ? ~last_q : Req1;

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && (Req0 || Req1)) begin
            last_d = win;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign win = ~Req0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    state_d = ACC1;
                    grant_d = win;
                    we_d    = win ? We1    : We0;
                    addr_d  = win ? Addr1  : Addr0;
                    wdata_d = win ? Wdata1 : Wdata0;
                end
            end
            ACC1:    state_d = ACC2;
            ACC2:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (state_q == ACC2 && !we_q) begin
                if (grant_q) begin
                    rdata1_q <= Mem_Din;
                end else begin
                    rdata0_q <= Mem_Din;
                end
            end
        end
    end

    assign active = (state_q == ACC1) || (state_q == ACC2);

    always_comb begin
        Busy        = (state_q != IDLE);
        Grant       = grant_q;
        Ack0        = 1'b0;
        Ack1        = 1'b0;
        Mem_ADDR    = '0;
        Mem_Dout    = wdata_q;
        Mem_Dout_en = 1'b0;
        Mem_OE      = 1'b1;
        Mem_WE      = 1'b1;
        if (state_q != IDLE) begin
            Mem_ADDR = addr_q;
        end
        if (active) begin
            Mem_Dout_en = we_q;
            Mem_WE      = ~we_q;
            Mem_OE      = we_q;
        end
        if (state_q == DONE) begin
            Ack0 = ~grant_q;
            Ack1 = grant_q;
        end
    end

    assign Rdata0 = rdata0_q;
    assign Rdata1 = rdata1_q;
    assign Mem_CE = 1'b0;
    assign Mem_UB = 1'b0;
    assign Mem_LB = 1'b0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a behavioural SRAM and an Ack scoreboard.
module tb_mem_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Req0, Req1, We0, We1;
    logic [AW-1:0] Addr0, Addr1;
    logic [DW-1:0] Wdata0, Wdata1;
    logic          Ack0, Ack1;
    logic [DW-1:0] Rdata0, Rdata1;
    logic [AW-1:0] Mem_ADDR;
    logic [DW-1:0] Mem_Dout, Mem_Din;
    logic          Mem_Dout_en, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Busy, Grant;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
        .Ack0(Ack0), .Ack1(Ack1), .Rdata0(Rdata0), .Rdata1(Rdata1),
        .Mem_ADDR(Mem_ADDR), .Mem_Dout(Mem_Dout), .Mem_Dout_en(Mem_Dout_en),
        .Mem_Din(Mem_Din), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Busy(Busy), .Grant(Grant)
    );

    always #5 Clk = ~Clk;

    logic [DW-1:0] sram [0:1023];
    assign Mem_Din = sram[Mem_ADDR[9:0]];
    always @(posedge Clk) begin
        if (Reset && !Mem_WE) sram[Mem_ADDR[9:0]] <= Mem_Dout;
    end

    typedef struct {
        logic          port;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_rd [2];
    int            checks = 0;
    int            errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expected Rdata for a write is whatever the port last read.
    task automatic push(input logic port, input logic is_wr, input logic [DW-1:0] rd);
        exp_t e;
        e.port = port;
        if (!is_wr) model_rd[port] = rd;
        e.rdata = model_rd[port];
        exp_q.push_back(e);
    endtask

    always @(negedge Clk) begin
        if (Reset && (Ack0 || Ack1)) begin
            check_eq("ack_both", {31'd0, Ack0 && Ack1}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("ack_unexpected", {31'd0, Ack1}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("ack_port", {31'd0, Ack1}, {31'd0, e.port});
                check_eq("ack_grant", {31'd0, Grant}, {31'd0, e.port});
                check_eq("ack_rdata", {16'd0, (Ack1 ? Rdata1 : Rdata0)}, {16'd0, e.rdata});
            end
        end
    end

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!(Ack0 || Ack1) && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 20) check_eq("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_acks"}, {30'd0, Ack1, Ack0}, 32'd0);
        check_eq({tag, "_busy_grant"}, {30'd0, Busy, Grant}, 32'd0);
        check_eq({tag, "_oe_we_en"}, {29'd0, Mem_OE, Mem_WE, Mem_Dout_en}, 32'b110);
        check_eq({tag, "_addr"}, {12'd0, Mem_ADDR}, 32'd0);
        check_eq({tag, "_rdata"}, {Rdata1, Rdata0}, 32'd0);
        check_eq({tag, "_ce_ub_lb"}, {29'd0, Mem_CE, Mem_UB, Mem_LB}, 32'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        exp_q.delete();
        model_rd[0] = '0;
        model_rd[1] = '0;
        step();
        step();
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b0;
        Req0 = 0; Req1 = 0; We0 = 0; We1 = 0;
        Addr0 = '0; Addr1 = '0; Wdata0 = '0; Wdata1 = '0;
        for (int i = 0; i < 1024; i++) sram[i] = '0;
        sram[10'h010] = 16'hBEEF;
        model_rd[0] = '0;
        model_rd[1] = '0;
        step();
        check_reset_vals("rst");
        step();
        Reset = 1'b1;
        step();

        // Read on port 0
        Req0 = 1; We0 = 0; Addr0 = 20'h00010;
        push(1'b0, 1'b0, 16'hBEEF);
        step();
        check_eq("rd_c1_oe_we", {30'd0, Mem_OE, Mem_WE}, 32'b01);
        check_eq("rd_c1_addr", {12'd0, Mem_ADDR}, 32'h10);
        check_eq("rd_c1_busy", {31'd0, Busy}, 32'd1);
        step();
        check_eq("rd_c2_oe_we", {30'd0, Mem_OE, Mem_WE}, 32'b01);
        check_eq("rd_c2_ack", {30'd0, Ack1, Ack0}, 32'd0);
        step();
        check_eq("rd_c3_ack0", {30'd0, Ack1, Ack0}, 32'b01);
        check_eq("rd_c3_oe_we", {30'd0, Mem_OE, Mem_WE}, 32'b11);
        Req0 = 0;
        step();
        check_eq("rd_idle_busy", {31'd0, Busy}, 32'd0);
        check_eq("rd_idle_addr", {12'd0, Mem_ADDR}, 32'd0);
        check_eq("rd_hold", {16'd0, Rdata0}, 32'hBEEF);

        // Write on port 1, then read it back on port 0
        Req1 = 1; We1 = 1; Addr1 = 20'h00200; Wdata1 = 16'h1234;
        push(1'b1, 1'b1, '0);
        step();
        for (int c = 1; c <= 2; c++) begin
            check_eq("wr_we_en_oe", {29'd0, Mem_WE, Mem_Dout_en, Mem_OE}, 32'b011);
            check_eq("wr_dout", {16'd0, Mem_Dout}, 32'h1234);
            check_eq("wr_addr", {12'd0, Mem_ADDR}, 32'h200);
            step();
        end
        check_eq("wr_done_ack1", {30'd0, Ack1, Ack0}, 32'b10);
        check_eq("wr_done_we_en", {30'd0, Mem_WE, Mem_Dout_en}, 32'b10);
        Req1 = 0;
        step();
        Req0 = 1; We0 = 0; Addr0 = 20'h00200;
        push(1'b0, 1'b0, 16'h1234);
        wait_ack();
        Req0 = 0;
        step();
        check_eq("wr_no_rdata1", {16'd0, Rdata1}, 32'd0);
        step();

        // Contention from a fresh reset
        do_reset();
        step();
        sram[10'h010] = 16'hBEEF;
        Req0 = 1; We0 = 0; Addr0 = 20'h00010;
        Req1 = 1; We1 = 0; Addr1 = 20'h00200;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        push(1'b0, 1'b0, 16'hBEEF);
        push(1'b1, 1'b0, 16'h1234);
        push(1'b0, 1'b0, 16'hBEEF);
        push(1'b1, 1'b0, 16'h1234);
`else
        for (int k = 0; k < 4; k++) push(1'b0, 1'b0, 16'hBEEF);
`endif
        for (int k = 0; k < 4; k++) begin
            wait_ack();
            if (k == 3) begin
                Req0 = 0;
                Req1 = 0;
            end
            step();
        end
        step();
        check_eq("cont_stop_busy", {31'd0, Busy}, 32'd0);
        check_eq("cont_queue", exp_q.size(), 32'd0);

        // Request dropped and address changed during ACC1
        Req0 = 1; We0 = 0; Addr0 = 20'h00010;
        push(1'b0, 1'b0, 16'hBEEF);
        step();
        Req0 = 0; Addr0 = 20'h00200;
        step();
        check_eq("mid_addr", {12'd0, Mem_ADDR}, 32'h10);
        wait_ack();
        step();
        check_eq("mid_queue", exp_q.size(), 32'd0);

        // Reset during ACC2 of a write
        Req1 = 1; We1 = 1; Addr1 = 20'h00300; Wdata1 = 16'h5555;
        step();
        step();
        check_eq("rst_acc2_we", {31'd0, Mem_WE}, 32'd0);
        #1 Reset = 1'b0;
        #1;
        check_eq("rst_async_we_busy", {30'd0, Mem_WE, Busy}, 32'b10);
        check_eq("rst_async_en", {31'd0, Mem_Dout_en}, 32'd0);
        Req1 = 0;
        model_rd[0] = '0;
        model_rd[1] = '0;
        step();
        Reset = 1'b1;
        step();
        check_reset_vals("post_rst");
        for (int c = 0; c < 4; c++) step();
        check_eq("post_rst_idle", {31'd0, Busy}, 32'd0);
        check_eq("final_queue", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
